regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Parametrised integer register file: NRD read ports, one write port, per-register busy scoreboard.
//  x0 is hardwired to zero. After reset, a sequential clear engine zeroes the array.
//  Sits between decode/issue (reads, busy checks, destination claims) and writeback.
// PARAMETERS
//  XLEN   32  data width in bits
//  NREGS  32  register count, power of 2, >=4; AW = $clog2(NREGS)
//  NRD    2   number of read ports, >=1
// PORTS
//  clk       in   1        clock, rising edge
//  rst_n     in   1        asynchronous, active-low reset
//  ready     out  1        1 = array cleared and accepting traffic
//  rs_addr   in   NRD*AW   read addresses; port k uses [k*AW +: AW]
//  rs_data   out  NRD*XLEN read data, combinational; port k uses [k*XLEN +: XLEN]
//  rs_busy   out  NRD      1 = register pending a writeback, combinational
//  iss_valid in   1        claim the destination register (mark it busy)
//  iss_rd    in   AW       destination register being claimed
//  we        in   1        writeback enable
//  rd_addr   in   AW       writeback address
//  wd        in   XLEN     writeback data
// BEHAVIOUR
//  Reset (rst_n=0, async): state=INIT, clr_idx=1, busy[]=0, ready=0. Array contents are undefined until INIT completes.
//  FSM INIT: each cycle writes regs[clr_idx]=0 and increments clr_idx.
//   - Transition INIT->RUN when clr_idx==NREGS-1 has been cleared.
//   - ready goes high on the first RUN cycle, which is exactly NREGS-1 edges after rst_n rises.
//  FSM RUN: terminal state; only reset leaves it.
//  INIT gating:
//   - we and iss_valid are ignored.
//   - rs_data=0 and rs_busy=0 on all ports.
//  Read port k:
//   - rs_addr==0 gives rs_data=0 and rs_busy=0.
//   - Otherwise rs_data=regs[addr] and rs_busy=busy[addr].
//  Write: if we && rd_addr!=0 in RUN, regs[rd_addr]<=wd at the edge. Writes to x0 are dropped.
//  Scoreboard, per register r!=0, evaluated at the edge:
//   - set   = iss_valid && iss_rd==r
//   - clr   = we && rd_addr==r
//   - busy[r] <= set ? 1 : (clr ? 0 : busy[r])
//   - Set wins over clear: a new producer claims r in the same cycle the old one retires.
//  Claims of x0 are ignored; busy[0] is constant 0.
//  Writeback to a non-busy register is legal: data is written and busy stays 0.
//  Several read ports may address the same register; each sees identical data and busy.
//  Reset asserted mid-operation: busy clears immediately (async) and INIT restarts at clr_idx=1.
//  No arithmetic beyond clr_idx increment; clr_idx is AW bits wide and never wraps in INIT.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined (write-first forwarding):
//   - In RUN, a read of addr==rd_addr!=0 while we=1 returns wd, and rs_busy=0 for that port.
//   - Exception: if iss_valid && iss_rd==addr in the same cycle, rs_busy=1.
//  REGFILE_BYPASS_EN undefined:
//   - Reads return the pre-edge array value and pre-edge busy bit.
//   - Consumers must wait one cycle after writeback.
// TESTING
//  1. rst_n low, then high:
//     - ready=0 for 31 cycles and 1 from the 32nd (NREGS=32).
//     - All 32 reads return 0 and busy=0.
//  2. RUN, we=1 rd_addr=5 wd=0xDEADBEEF; next cycle read 5 on both ports:
//     - Both return 0xDEADBEEF.
//     - Writing 0x1234 to x0 leaves a read of x0 at 0.
//  3. iss_valid iss_rd=7:
//     - busy[7]=1 the next cycle.
//     - Then we rd_addr=7 wd=0x55: busy[7]=0 and data=0x55.
//     - Same-cycle claim+write of 7 leaves busy[7]=1.
//  4. With REGFILE_BYPASS_EN, same-cycle we rd_addr=3 wd=0xA5A5A5A5 and read 3 -> rs_data=0xA5A5A5A5, rs_busy=0.
//     Without REGFILE_BYPASS_EN, the old value is returned.
//  5. Pulse rst_n low mid-INIT (clr_idx=10) and mid-RUN with busy[9]=1:
//     - busy clears at once and ready drops at once.
//     - INIT restarts at 1 and the full clear repeats.
//  6. During INIT, we=1 rd_addr=4 wd=0xFF and iss_valid iss_rd=4:
//     - After ready, reg 4 reads 0 and busy[4]=0.

Source files
------------

// File: rtl/regfile_sb_if.sv
// ============================================================================
// Module      : regfile_sb_if
// Description : Issue/read/writeback bundle for the regfile_sb register file.
//               The master side (decode/issue + writeback) drives addresses,
//               claims and write data. The slave side (register file) returns
//               read data, busy bits and ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) ();
    localparam int AW = $clog2(NREGS);

    logic                ready;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                we;
    logic [AW-1:0]       rd_addr;
    logic [XLEN-1:0]     wd;

    modport master (
        input  ready, rs_data, rs_busy,
        output rs_addr, iss_valid, iss_rd, we, rd_addr, wd
    );

    modport slave (
        input  rs_addr, iss_valid, iss_rd, we, rd_addr, wd,
        output ready, rs_data, rs_busy
    );
endinterface

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// Module      : regfile_sb
// Description : Parametrised integer register file with NRD combinational
//               read ports, one write port and a per-register busy
//               scoreboard. x0 reads as zero. After reset a clear engine
//               zeroes x1..x(NREGS-1) one per cycle, then ready rises.
//               Optional feature macro: REGFILE_BYPASS_EN (write-first
//               forwarding of the same-cycle writeback to the read ports).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    regfile_sb_if.slave bus
);
    localparam int            AW         = $clog2(NREGS);
    localparam logic [AW-1:0] c_LAST_IDX = AW'(NREGS - 1);
    localparam logic [AW-1:0] c_ONE      = AW'(1);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    logic [AW-1:0]     r_clr_idx;
    logic              r_ready;
    logic [XLEN-1:0]   r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;

    logic              w_run;
    logic              w_wr_en;
    logic              w_claim_en;
    logic [NRD*XLEN-1:0] w_rs_data;
    logic [NRD-1:0]      w_rs_busy;

    // Writes and claims only take effect once the array has been cleared;
    // anything aimed at x0 is discarded here so x0 never changes.
    assign w_run      = (r_state == S_RUN);
    assign w_wr_en    = w_run && bus.we        && (bus.rd_addr != '0);
    assign w_claim_en = w_run && bus.iss_valid && (bus.iss_rd  != '0);

    // Clear engine / run FSM: walks clr_idx from 1 to NREGS-1, then parks in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_INIT;
            r_clr_idx <= c_ONE;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_clr_idx == c_LAST_IDX) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_clr_idx <= r_clr_idx + c_ONE;
                    end
                end
                S_RUN: begin
                    r_state <= S_RUN;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state   <= S_INIT;
                    r_clr_idx <= c_ONE;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: no reset so it maps onto plain flops/RAM; the clear
    // engine owns the write port while in INIT.
    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_regs[r_clr_idx] <= '0;
        end else if (w_wr_en) begin
            r_regs[bus.rd_addr] <= bus.wd;
        end
    end

    // Scoreboard: retire on writeback, claim on issue; the claim is applied
    // last so a new producer wins over the retiring one. Bit 0 is never set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            if (w_wr_en) begin
                r_busy[bus.rd_addr] <= 1'b0;
            end
            if (w_claim_en) begin
                r_busy[bus.iss_rd] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd_port
        logic [AW-1:0]   w_addr;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_addr = bus.rs_addr[k*AW +: AW];

        // Read mux: zero while clearing or for x0, otherwise array/scoreboard.
        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if (w_run && (w_addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
                if (bus.we && (bus.rd_addr == w_addr)) begin
                    // Forward the retiring value; a same-cycle re-claim
                    // still marks the register as pending.
                    w_data = bus.wd;
                    w_busy = bus.iss_valid && (bus.iss_rd == w_addr);
                end else begin
                    w_data = r_regs[w_addr];
                    w_busy = r_busy[w_addr];
                end
`else
                w_data = r_regs[w_addr];
                w_busy = r_busy[w_addr];
`endif
            end
        end

        assign w_rs_data[k*XLEN +: XLEN] = w_data;
        assign w_rs_busy[k]              = w_busy;
    end

    assign bus.rs_data = w_rs_data;
    assign bus.rs_busy = w_rs_busy;
    assign bus.ready   = r_ready;

endmodule

`default_nettype wire
